// File: rtl/conv_window_feeder.sv
// rtl/conv_window_feeder.sv - F x F x CIN sliding-window feeder (optional win_last via CONV_WINDOW_FEEDER_LAST_EN)
module conv_window_feeder #(
    parameter int WIDTH  = 8,
    parameter int F      = 5,
    parameter int CIN    = 3,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int STRIDE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH*CIN-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     win [0:CIN*F*F-1],
    output logic                 win_valid,
    input  logic                 win_ready
`ifdef CONV_WINDOW_FEEDER_LAST_EN
    ,
    output logic                 win_last
`endif
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LAST_ROW = IMG_H - 1 - ((IMG_H - F) % STRIDE);
    localparam int LAST_COL = IMG_W - 1 - ((IMG_W - F) % STRIDE);

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic             accept;
    logic             complete;
    logic             last_pos;

    // lb[c][0] holds the oldest buffered row, lb[c][F-2] the most recent one
    logic [WIDTH-1:0] lb      [CIN][F-1][IMG_W];
    logic [WIDTH-1:0] sw      [CIN][F][F];
    logic [WIDTH-1:0] new_col [CIN][F];
    logic [WIDTH-1:0] nxt     [CIN][F][F];

    assign in_ready = !win_valid || win_ready;
    assign accept   = in_valid && in_ready;

    // Build the incoming column and the window as it will look after this accept
    always_comb begin
        for (int c = 0; c < CIN; c++) begin
            for (int r = 0; r < F - 1; r++) begin
                new_col[c][r] = lb[c][r][col];
            end
            new_col[c][F-1] = in_data[c*WIDTH +: WIDTH];
            for (int r = 0; r < F; r++) begin
                for (int k = 0; k < F - 1; k++) begin
                    nxt[c][r][k] = sw[c][r][k+1];
                end
                nxt[c][r][F-1] = new_col[c][r];
            end
        end
    end

    // Decide whether the pixel at (row, col) closes a strided output position
    always_comb begin
        complete = (int'(row) >= F - 1) && (int'(col) >= F - 1) &&
                   (((int'(row) - (F - 1)) % STRIDE) == 0) &&
                   (((int'(col) - (F - 1)) % STRIDE) == 0);
        last_pos = (int'(row) == LAST_ROW) && (int'(col) == LAST_COL);
    end

    // Line buffers and shift window; contents are masked by the counters so no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int c = 0; c < CIN; c++) begin
                for (int j = 0; j < F - 2; j++) begin
                    lb[c][j][col] <= lb[c][j+1][col];
                end
                lb[c][F-2][col] <= in_data[c*WIDTH +: WIDTH];
                for (int r = 0; r < F; r++) begin
                    for (int k = 0; k < F; k++) begin
                        sw[c][r][k] <= nxt[c][r][k];
                    end
                end
            end
        end
    end

    // Raster counters and the registered output window with its valid flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
            for (int i = 0; i < CIN*F*F; i++) begin
                win[i] <= '0;
            end
`ifdef CONV_WINDOW_FEEDER_LAST_EN
            win_last  <= 1'b0;
`endif
        end else begin
            if (accept) begin
                if (col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    if (row == RW'(IMG_H - 1)) begin
                        row <= '0;
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (accept && complete) begin
                win_valid <= 1'b1;
                for (int c = 0; c < CIN; c++) begin
                    for (int r = 0; r < F; r++) begin
                        for (int k = 0; k < F; k++) begin
                            win[c*F*F + r*F + k] <= nxt[c][r][k];
                        end
                    end
                end
`ifdef CONV_WINDOW_FEEDER_LAST_EN
                win_last  <= last_pos;
`endif
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

`ifndef CONV_WINDOW_FEEDER_LAST_EN
    logic unused_last;
    assign unused_last = last_pos;
`endif

endmodule

// File: tb/tb_conv_window_feeder.sv
// tb/tb_conv_window_feeder.sv - directed self-checking bench for conv_window_feeder
module tb_conv_window_feeder;

    localparam int N = 75;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] in_data;
    logic        in_valid;
    logic        win_ready;
    logic        in_ready1, in_ready2;
    logic        win_valid1, win_valid2;
    logic [7:0]  win1 [0:N-1];
    logic [7:0]  win2 [0:N-1];
`ifdef CONV_WINDOW_FEEDER_LAST_EN
    logic        win_last1, win_last2;
`endif

    always #5 clk = ~clk;

    conv_window_feeder #(.WIDTH(8), .F(5), .CIN(3), .IMG_W(8), .IMG_H(8), .STRIDE(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
        .win(win1), .win_valid(win_valid1), .win_ready(win_ready)
`ifdef CONV_WINDOW_FEEDER_LAST_EN
        , .win_last(win_last1)
`endif
    );

    conv_window_feeder #(.WIDTH(8), .F(5), .CIN(3), .IMG_W(8), .IMG_H(8), .STRIDE(2)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
        .win(win2), .win_valid(win_valid2), .win_ready(win_ready)
`ifdef CONV_WINDOW_FEEDER_LAST_EN
        , .win_last(win_last2)
`endif
    );

    int checks = 0;
    int errors = 0;
    int p, cnt1, cnt2, first_p1;
    int er1, ec1, er2, ec2;
    bit pend1, pend2;
    logic [7:0] first1  [0:N-1];
    logic [7:0] f2first [0:N-1];
    logic [7:0] last2   [0:N-1];

    function automatic logic [7:0] pixv(input int c, input int r, input int k);
        return 8'(c*64 + r*8 + k);
    endfunction

    function automatic bit completes(input int r, input int k, input int s);
        return (r >= 4) && (k >= 4) && ((r - 4) % s == 0) && ((k - 4) % s == 0);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        win_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        p = 0; pend1 = 0; pend2 = 0; cnt1 = 0; cnt2 = 0; first_p1 = -1;
    endtask

    task automatic run(input int target, input int stall_len, input bit chk2, input bit drain);
        int stall_left;
        int cyc;
        int pos, r, k;
        int bi, ba, be;
        bit acc, stalling;
        stall_left = stall_len;
        cyc = 0;
        while ((p < target || (drain && (pend1 || (chk2 && pend2)))) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            pos = p % 64; r = pos / 8; k = pos % 8;
            in_valid = (p < target);
            in_data = {pixv(2, r, k), pixv(1, r, k), pixv(0, r, k)};
            stalling = pend1 && (cnt1 == 0) && (stall_left > 0);
            if (stalling) stall_left--;
            win_ready = !stalling;
            #1;
            checks++;
            if (win_valid1 !== pend1) begin
                errors++; $display("FAIL win_valid1 p=%0d got %b want %b", p, win_valid1, pend1);
            end
            checks++;
            if (in_ready1 !== (!pend1 || win_ready)) begin
                errors++; $display("FAIL in_ready1 p=%0d got %b want %b", p, in_ready1, !pend1 || win_ready);
            end
            if (pend1) begin
                bi = -1; ba = 0; be = 0;
                for (int c = 0; c < 3; c++)
                    for (int rr = 0; rr < 5; rr++)
                        for (int kk = 0; kk < 5; kk++)
                            if (bi < 0 && win1[c*25 + rr*5 + kk] !== pixv(c, er1 - 4 + rr, ec1 - 4 + kk)) begin
                                bi = c*25 + rr*5 + kk; ba = int'(win1[bi]); be = int'(pixv(c, er1 - 4 + rr, ec1 - 4 + kk));
                            end
                checks++;
                if (bi >= 0) begin
                    errors++; $display("FAIL window1 at (%0d,%0d) idx %0d got %0d want %0d", er1, ec1, bi, ba, be);
                end
`ifdef CONV_WINDOW_FEEDER_LAST_EN
                checks++;
                if (win_last1 !== (er1 == 7 && ec1 == 7)) begin
                    errors++; $display("FAIL win_last1 at (%0d,%0d) got %b", er1, ec1, win_last1);
                end
`endif
                if (win_ready) begin
                    if (cnt1 == 0) begin first1 = win1; first_p1 = p; end
                    if (cnt1 == 16) f2first = win1;
                    cnt1++;
                end
            end
            if (chk2) begin
                checks++;
                if (win_valid2 !== pend2) begin
                    errors++; $display("FAIL win_valid2 p=%0d got %b want %b", p, win_valid2, pend2);
                end
                if (pend2) begin
                    bi = -1; ba = 0; be = 0;
                    for (int c = 0; c < 3; c++)
                        for (int rr = 0; rr < 5; rr++)
                            for (int kk = 0; kk < 5; kk++)
                                if (bi < 0 && win2[c*25 + rr*5 + kk] !== pixv(c, er2 - 4 + rr, ec2 - 4 + kk)) begin
                                    bi = c*25 + rr*5 + kk; ba = int'(win2[bi]); be = int'(pixv(c, er2 - 4 + rr, ec2 - 4 + kk));
                                end
                    checks++;
                    if (bi >= 0) begin
                        errors++; $display("FAIL window2 at (%0d,%0d) idx %0d got %0d want %0d", er2, ec2, bi, ba, be);
                    end
`ifdef CONV_WINDOW_FEEDER_LAST_EN
                    checks++;
                    if (win_last2 !== (er2 == 6 && ec2 == 6)) begin
                        errors++; $display("FAIL win_last2 at (%0d,%0d) got %b", er2, ec2, win_last2);
                    end
`endif
                    last2 = win2;
                    cnt2++;
                end
            end
            acc = in_valid && (!pend1 || win_ready);
            if (acc && completes(r, k, 1)) begin pend1 = 1; er1 = r; ec1 = k; end
            else if (win_ready) pend1 = 0;
            if (chk2) begin
                if (in_valid && completes(r, k, 2)) begin pend2 = 1; er2 = r; ec2 = k; end
                else pend2 = 0;
            end
            if (acc) p++;
        end
        if (cyc >= 1000) begin
            checks++; errors++;
            $display("FAIL run_timeout p=%0d got %0d cycles want <1000", p, cyc);
        end
    endtask

    task automatic test_reset();
        bit allz;
        rst = 1'b1; in_valid = 1'b0; win_ready = 1'b0; in_data = '0;
        #2;
        allz = 1;
        for (int i = 0; i < N; i++) if (win1[i] !== 8'd0) allz = 0;
        checks++;
        if (win_valid1 !== 1'b0 || win_valid2 !== 1'b0) begin
            errors++; $display("FAIL reset_win_valid got %b%b want 00", win_valid1, win_valid2);
        end
        checks++;
        if (in_ready1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready1); end
        checks++;
        if (!allz) begin errors++; $display("FAIL reset_win got nonzero want all 0"); end
`ifdef CONV_WINDOW_FEEDER_LAST_EN
        checks++;
        if (win_last1 !== 1'b0) begin errors++; $display("FAIL reset_win_last got %b want 0", win_last1); end
`endif
    endtask

    task automatic test_stream();
        do_reset();
        run(64, 0, 1, 1);
        checks++; if (cnt1 != 16) begin errors++; $display("FAIL stream_count got %0d want 16", cnt1); end
        checks++; if (first_p1 != 37) begin errors++; $display("FAIL first_latency got p=%0d want 37", first_p1); end
        checks++; if (first1[0] !== 8'd0) begin errors++; $display("FAIL first_w0 got %0d want 0", first1[0]); end
        checks++; if (first1[24] !== 8'd36) begin errors++; $display("FAIL first_w24 got %0d want 36", first1[24]); end
        checks++; if (first1[25] !== 8'd64) begin errors++; $display("FAIL first_w25 got %0d want 64", first1[25]); end
        checks++; if (first1[74] !== 8'd164) begin errors++; $display("FAIL first_w74 got %0d want 164", first1[74]); end
    endtask

    task automatic test_stride2();
        do_reset();
        run(64, 0, 1, 1);
        checks++; if (cnt2 != 4) begin errors++; $display("FAIL stride2_count got %0d want 4", cnt2); end
        checks++; if (last2[0] !== 8'd18) begin errors++; $display("FAIL stride2_last_w0 got %0d want 18", last2[0]); end
        checks++; if (last2[24] !== 8'd54) begin errors++; $display("FAIL stride2_last_w24 got %0d want 54", last2[24]); end
    endtask

    task automatic test_backpressure();
        do_reset();
        run(64, 10, 0, 1);
        checks++; if (cnt1 != 16) begin errors++; $display("FAIL bp_count got %0d want 16", cnt1); end
        checks++; if (first1[24] !== 8'd36) begin errors++; $display("FAIL bp_first_w24 got %0d want 36", first1[24]); end
    endtask

    task automatic test_back_to_back();
        int bad;
        do_reset();
        run(128, 0, 1, 1);
        checks++; if (cnt1 != 32) begin errors++; $display("FAIL b2b_count got %0d want 32", cnt1); end
        checks++; if (cnt2 != 8) begin errors++; $display("FAIL b2b_count2 got %0d want 8", cnt2); end
        bad = -1;
        for (int i = 0; i < N; i++) if (bad < 0 && f2first[i] !== pixv(i / 25, (i % 25) / 5, i % 5)) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++; $display("FAIL b2b_frame2_first idx %0d got %0d want %0d", bad, f2first[bad], pixv(bad / 25, (bad % 25) / 5, bad % 5));
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        run(45, 0, 0, 0);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        checks++;
        if (win_valid1 !== 1'b1) begin errors++; $display("FAIL midreset_pre_valid got %b want 1", win_valid1); end
        rst = 1'b1;
        #1;
        checks++;
        if (win_valid1 !== 1'b0) begin errors++; $display("FAIL midreset_valid_drop got %b want 0", win_valid1); end
        checks++;
        if (in_ready1 !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got %b want 1", in_ready1); end
        @(negedge clk);
        rst = 1'b0;
        p = 0; pend1 = 0; pend2 = 0; cnt1 = 0; cnt2 = 0; first_p1 = -1;
        run(64, 0, 0, 1);
        checks++; if (cnt1 != 16) begin errors++; $display("FAIL midreset_count got %0d want 16", cnt1); end
        checks++; if (first1[74] !== 8'd164) begin errors++; $display("FAIL midreset_first_w74 got %0d want 164", first1[74]); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stride2();
        test_backpressure();
        test_back_to_back();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
